// File: rtl/nn_weight_loader.sv
// Streams a valid/ready weight sequence into the per-node shift registers of the
// two-layer network: one-hot node select on `we`, weight word on `bus`.
module nn_weight_loader #(
  parameter int sx  = 4,
  parameter int sl1 = 3,
  parameter int sl2 = 2,
  parameter int nd  = sl1 + sl2,
  parameter int n   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic signed [n-1:0] w_in,
  input  logic                w_valid,
  output logic                w_ready,
  output logic [nd-1:0]       we,
  output logic signed [n-1:0] bus,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  localparam int wt   = sx * sl1 + sl1 * sl2;
  localparam int lmax = (sx > sl1) ? sx : sl1;
  localparam int wcw  = $clog2(lmax + 1);
  localparam int ncw  = $clog2(nd + 1);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_load = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  if (nd != sl1 + sl2 || wt < nd) begin : g_bad_params
    $error("nn_weight_loader: nd must equal sl1+sl2");
  end

  // Handshake: a beat transfers on a rising edge where w_valid && w_ready;
  // w_ready is high exactly while loading and never depends on w_valid.
  logic [1:0]     state;
  logic [wcw-1:0] word;
  logic [ncw-1:0] node;
  logic           accept;
  logic           word_wrap;
  logic           final_beat;
  logic [nd-1:0]  sel;
  int             lim;

  always_comb begin
    lim        = (int'(node) < sl1) ? sx : sl1;
    accept     = w_valid && (state == st_load);
    word_wrap  = (int'(word) == lim - 1);
    final_beat = word_wrap && (int'(node) == nd - 1);
    sel        = '0;
    // Layer-1 node 0 lives on the top bit of we.
    for (int i = 0; i < nd; i++) sel[i] = (int'(node) == nd - 1 - i);
  end

  assign w_ready   = (state == st_load);
  assign busy      = (state != st_idle);
  assign done      = (state == st_done);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= st_idle;
      word  <= '0;
      node  <= '0;
      we    <= '0;
      bus   <= '0;
    end else begin
      case (state)
        st_idle: begin
          we <= '0;
          if (start) begin
            state <= st_load;
            word  <= '0;
            node  <= '0;
          end
        end
        st_load: begin
          if (abort) begin
            // A beat arriving with abort is dropped; nodes keep partial contents.
            state <= st_idle;
            word  <= '0;
            node  <= '0;
            we    <= '0;
          end else if (accept) begin
            bus <= w_in;
            we  <= sel;
            if (word_wrap) begin
              word <= '0;
              node <= node + ncw'(1);
            end else begin
              word <= word + wcw'(1);
            end
            if (final_beat) state <= st_done;
          end else begin
            we <= '0;
          end
        end
        st_done: begin
          state <= st_idle;
          word  <= '0;
          node  <= '0;
          we    <= '0;
        end
        default: begin
          state <= st_idle;
          we    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_weight_loader.sv
// Bench for nn_weight_loader: directed and randomized loads checked against a
// beat-index model of the node/word mapping.
module tb_nn_weight_loader;

  localparam int sx  = 3;
  localparam int sl1 = 2;
  localparam int sl2 = 2;
  localparam int nd  = 4;
  localparam int n   = 16;
  localparam int wt  = sx * sl1 + sl1 * sl2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic signed [n-1:0] w_in = '0;
  logic                w_valid = 1'b0;
  logic                w_ready;
  logic [nd-1:0]       we;
  logic signed [n-1:0] bus;
  logic                busy;
  logic                done;
  logic [1:0]          state_dbg;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [nd+n-1:0] exp_q[$];
  logic [nd+n-1:0] obs_q[$];

  // clock / reset
  always #5 clk = ~clk;

  nn_weight_loader #(.sx(sx), .sl1(sl1), .sl2(sl2), .nd(nd), .n(n)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .w_in(w_in),
    .w_valid(w_valid), .w_ready(w_ready), .we(we), .bus(bus), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  always @(negedge clk) begin
    if (we != '0) obs_q.push_back({we, bus});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: beat k belongs to layer-1 node k/sx, then layer-2 nodes in groups of sl1
  function automatic int node_of(input int k);
    if (k < sx * sl1) return k / sx;
    return sl1 + (k - sx * sl1) / sl1;
  endfunction

  function automatic logic [nd-1:0] we_of(input int k);
    logic [nd-1:0] one;
    one = 1;
    return one << (nd - 1 - node_of(k));
  endfunction

  // mode 0: continuous, 1: alternate 1,0,..., 2: random stalls
  task automatic do_load(input string name, input int mode, input int abort_beat,
                         input int start_beat, input int reset_beat, input bit rnd);
    logic signed [n-1:0] data [wt];
    int k;
    int cyc;
    bit v;
    bit ab;
    bit aborted;
    bit fin;
    for (int i = 0; i < wt; i++) data[i] = rnd ? n'($urandom) : n'(i + 1);
    exp_q.delete();
    obs_q.delete();
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "/ready_after_start"}, w_ready, 1);
    check({name, "/busy_after_start"}, busy, 1);
    k = 0; cyc = 0; fin = 0; aborted = 0;
    while (!fin && cyc < 100) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      ab      = v && (k + 1 == abort_beat);
      w_valid = v;
      w_in    = v ? data[k] : n'($urandom);
      abort   = ab;
      start   = v && (k + 1 == start_beat);
      check({name, "/ready_in_load"}, w_ready, 1);
      if (v && k + 1 == reset_beat) begin
        #2 rst = 1'b0;
        #1;
        check({name, "/rst_we"}, we, 0);
        check({name, "/rst_bus"}, bus, 0);
        check({name, "/rst_busy"}, busy, 0);
        check({name, "/rst_ready"}, w_ready, 0);
        check({name, "/rst_done"}, done, 0);
        w_valid = 1'b0; abort = 1'b0; start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check({name, "/post_rst_busy"}, busy, 0);
        check({name, "/post_rst_ready"}, w_ready, 0);
        check({name, "/post_rst_we"}, we, 0);
        return;
      end
      @(posedge clk); #1;
      w_valid = 1'b0; abort = 1'b0; start = 1'b0;
      if (v && !ab) begin
        exp_q.push_back({we_of(k), data[k]});
        check({name, "/we"}, we, we_of(k));
        check({name, "/bus"}, bus, data[k]);
        check({name, "/done"}, done, (k == wt - 1));
      end else begin
        check({name, "/we_idle"}, we, 0);
        check({name, "/done_idle"}, done, 0);
      end
      if (v) k++;
      if (ab) aborted = 1;
      if (ab || k == wt) fin = 1;
      cyc++;
    end
    check({name, "/load_finished"}, fin, 1);
    if (aborted) begin
      check({name, "/abort_busy"}, busy, 0);
      check({name, "/abort_ready"}, w_ready, 0);
    end else begin
      check({name, "/done_busy"}, busy, 1);
      @(posedge clk); #1;
      check({name, "/end_busy"}, busy, 0);
      check({name, "/end_we"}, we, 0);
      check({name, "/end_done"}, done, 0);
      check({name, "/end_ready"}, w_ready, 0);
    end
    @(negedge clk); #1;
    check({name, "/pulse_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({name, "/pulse_seq"}, obs_q[i], exp_q[i]);
    check({name, "/done_count"}, done_cnt, aborted ? 0 : 1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/ready", w_ready, 0);
    check("reset/we", we, 0);
    check("reset/bus", bus, 0);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    rst = 1'b1;
    w_valid = 1'b1;
    w_in = n'($urandom);
    repeat (5) begin
      @(posedge clk); #1;
      check("idle/ready", w_ready, 0);
      check("idle/we", we, 0);
      check("idle/busy", busy, 0);
      check("idle/done", done, 0);
    end
    w_valid = 1'b0;

    do_load("stream", 0, 0, 0, 0, 1'b0);
    do_load("stall", 1, 0, 0, 0, 1'b0);
    do_load("abort", 0, 5, 0, 0, 1'b0);
    do_load("restart", 0, 0, 0, 0, 1'b0);
    do_load("start_in_load", 0, 0, 6, 0, 1'b0);
    do_load("rst_mid", 0, 0, 0, 7, 1'b0);
    do_load("after_rst", 0, 0, 0, 0, 1'b1);
    repeat (3) do_load("random", 2, 0, 0, 0, 1'b1);
    do_load("rand_abort", 2, $urandom_range(1, wt), 0, 0, 1'b1);
    do_load("rand_start", 2, 0, $urandom_range(1, wt), 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nn_weight_loader.md
# nn_weight_loader

Sequencer that streams trained weights into the per-node weight shift registers of the two-layer network top (`ai_top`-style datapath). It accepts a valid/ready weight stream and converts it into the network's `bus` data word plus a one-hot `we` node-select vector. It walks every node of hidden layer 1, then every node of layer 2, in the network's fixed node order. It sits between the host/memory weight source and the network top, and signals completion so inference can start.

## Interface
- `sx`, default 4: inputs per layer-1 node, i.e. weights per layer-1 node.
- `sl1`, default 3: layer-1 node count, which is also the weights per layer-2 node.
- `sl2`, default 2: layer-2 (output) node count.
- `nd`, default `sl1+sl2`: total nodes and width of `we`. Elaborating with any other value is an error.
- `wt`, derived as `sx*sl1 + sl1*sl2`: total weights per load. Not overridable.
- `n`, from `` `n `` in fixed_point.vh: word width.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; asserted when 0.
- `start`  in  1  one-cycle request to begin a full load.
- `abort`  in  1  cancels a load in progress.
- `w_in`  in  n, signed  weight word from the source.
- `w_valid`  in  1  `w_in` is valid.
- `w_ready`  out  1  loader accepts `w_in` this cycle.
- `we`  out  nd  one-hot shift enable per node; bit `nd-1` is layer-1 node 0.
- `bus`  out  n, signed  weight word to the node shift registers.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse after the final weight is presented.

## Operation
- Reset: state IDLE. `w_ready`, `we`, `bus`, `busy` and `done` all read 0. Node and word counters are 0.
- States are IDLE, LOAD and DONE.
- IDLE:
  - `start`=1 moves the block to LOAD, with `node`=0 and `word`=0.
  - `abort` is ignored.
- LOAD:
  - `w_ready`=1 combinationally.
  - A beat is accepted when `w_valid & w_ready`.
  - On each accepted beat, the registered outputs update next cycle: `bus` <= `w_in` and `we` <= one-hot at bit `nd-1-node`.
  - On a cycle with no accept, `we` <= 0 and `bus` holds its value.
  - Per-node limit is `sx` while `node < sl1`, and `sl1` otherwise.
  - Counters: `word` increments on each accept. When `word` reaches limit-1 it wraps to 0 and `node` increments.
  - On the accept of the last word of node `nd-1`, the block moves to DONE.
- DONE:
  - `we` carries the final beat this cycle and `done`=1.
  - Next cycle the block returns to IDLE with `we`=0.
- `busy` = state != IDLE.
- `start` while in LOAD or DONE is ignored. It does not restart the load.
- `abort` in LOAD:
  - Next state is IDLE and counters clear.
  - A beat accepted in the same cycle is discarded: `we` <= 0 and `done` is not pulsed.
  - Node registers keep partial contents; software must reload.
- Word order within a node is the shift order: the first word accepted is the first word shifted in.
- Counter widths are `$clog2(max(sx,sl1)+1)` and `$clog2(nd+1)`. No arithmetic is done on weight data.

## Timing
- `w_ready` rises in the cycle after `start` is sampled.
- Latency from an accepted beat (edge T) to `we`/`bus` being valid is one cycle: valid during T+1, sampled by the nodes at edge T+1.
- At most one `we` bit is high in any cycle.
- `we` pulses exactly once per accepted beat.
- Back-to-back `w_valid` gives a full load in `wt` accept cycles. `done` pulses in the cycle after the last accept.
- Source stalls (`w_valid`=0) insert `we`=0 cycles. No timeout exists.
- Asynchronous reset mid-LOAD forces all outputs to 0 immediately.

## Test plan
Parameters for all scenarios: sx=3, sl1=2, sl2=2, nd=4, wt=10.
- Reset then idle:
  - Stimulus: `rst` low, then released; `w_valid`=1 with no `start`.
  - Required: `w_ready`=0, `we`=0, `busy`=0, `done`=0 throughout.
- Full streaming load:
  - Stimulus: `start`, then w=1..10 with `w_valid` held high.
  - Required: `we`=1000 for words 1-3, 0100 for 4-6, 0010 for 7-8, 0001 for 9-10. `bus` equals each word one cycle after its accept. `done` pulses once, together with `bus`=10.
- Stalled source:
  - Stimulus: the same load with `w_valid` toggled 1,0,1,0.
  - Required: exactly 10 `we` pulses with the same mapping. `we`=0 in every stall cycle. `done` pulses once.
- Abort mid-load:
  - Stimulus: `abort` asserted together with the 5th accept.
  - Required: 4 `we` pulses only; word 5 never appears with `we`≠0. `busy`=0 next cycle. No `done`.
  - Follow-up: a new `start` must restart at `we`=1000.
- `start` during LOAD:
  - Stimulus: `start` pulsed at word 6.
  - Required: the sequence continues unchanged to `done` after word 10.
- Async reset mid-load:
  - Stimulus: `rst`=0 during word 7.
  - Required: `we`, `bus`, `busy` and `w_ready` go to 0 before the next edge. Returns to IDLE.
